board_cursor_ctrl: RTL and testbench
====================================

Name: board_cursor_ctrl

Overview:
Player-input stage directly upstream of the VGA board renderer. Conditions raw push-buttons, moves the cursor over the 8x8 board, and runs the select/deselect/commit state machine. Drives CURSOR_ADDR, SELECT_ADDR and SELECT_EN to the renderer. Issues move requests over a req/ack handshake to the game-logic block that owns BOARD.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable synchronized cycles required before a button level is accepted (sim uses 4)
START_ADDR, 6'd52, cursor address after reset ({row,col} = row 6, col 4)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-low reset
BTN_UP / BTN_DOWN / BTN_LEFT / BTN_RIGHT / BTN_CENTER  in  1 each  raw asynchronous buttons, active-high
BOARD  in  256  square n = BOARD[4n+3:4n]; [2:0] piece code, [3] colour (0 white, 1 black)
TURN  in  1  side to move (0 white, 1 black)
MOVE_ACK  in  1  game logic has consumed the request; sampled only in REQUEST
MOVE_OK  in  1  qualifies MOVE_ACK: 1 move applied, 0 move rejected
CURSOR_ADDR  out  6  {row,col} of cursor
SELECT_ADDR  out  6  {row,col} of selected square
SELECT_EN  out  1  a square is selected
MOVE_REQ  out  1  move request valid
MOVE_FROM  out  6  source square
MOVE_TO  out  6  destination square

Behaviour:
- Reset (RESET low, asynchronous) sets CURSOR_ADDR=START_ADDR, SELECT_ADDR=0, SELECT_EN=0, MOVE_REQ=0, MOVE_FROM=0, MOVE_TO=0, FSM=IDLE, and clears all conditioner state. Reset mid-REQUEST drops MOVE_REQ immediately.
- Button conditioner, one per button:
  - 2-flop synchronizer.
  - Counter clears whenever the synchronized level equals the debounced level; otherwise it increments.
  - The debounced level flips when the counter reaches DEBOUNCE_CYCLES-1.
  - A rising edge of the debounced level gives a registered 1-cycle pulse.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse. Release is debounced identically and produces no pulse.
- Latency: a stable raw press first sampled at edge k changes registered outputs at edge k+DEBOUNCE_CYCLES+3.
- Per-cycle pulse priority: CENTER > UP > DOWN > LEFT > RIGHT. Exactly one pulse is acted on per cycle; the others are discarded.
- Cursor arithmetic, 3-bit modulo-8 wrap:
  - UP: row-1 (0 wraps to 7). DOWN: row+1 (7 wraps to 0).
  - LEFT: col-1 (0 wraps to 7). RIGHT: col+1 (7 wraps to 0).
  - Cursor is frozen in REQUEST.
- "Own piece at s" means BOARD square s has [2:0]!=0 and [3]==TURN.
- FSM states and transitions:
  - IDLE, on CENTER:
    - own piece at cursor: SELECT_ADDR<=cursor, SELECT_EN<=1, go to SELECTED.
    - otherwise: no change.
  - SELECTED, on CENTER:
    - cursor==SELECT_ADDR: SELECT_EN<=0, go to IDLE.
    - else own piece at cursor: SELECT_ADDR<=cursor, stay in SELECTED.
    - else: MOVE_FROM<=SELECT_ADDR, MOVE_TO<=cursor, MOVE_REQ<=1, go to REQUEST.
  - REQUEST:
    - MOVE_REQ, MOVE_FROM, MOVE_TO and SELECT_* held stable; all button pulses discarded.
    - On an edge with MOVE_ACK=1, MOVE_REQ<=0 and:
      - MOVE_OK=1: SELECT_EN<=0, go to IDLE.
      - MOVE_OK=0: keep selection, go to SELECTED.
- MOVE_ACK outside REQUEST is ignored. MOVE_ACK asserted in the same cycle MOVE_REQ rises is valid; the request completes after one cycle.
- BOARD and TURN are sampled only on the CENTER-pulse cycle. A TURN change while in SELECTED does not clear the selection.
- MOVE_FROM and MOVE_TO retain their last values after the handshake.

Decomposition:
- Shared package chess_pkg holds:
  - piece codes PIECE_NONE..PIECE_KING (3 bits), COLOR_WHITE=0, COLOR_BLACK=1;
  - square address width 6 and the {row,col} layout;
  - FSM encoding IDLE/SELECTED/REQUEST.
- Sub-module btn_conditioner (synchronizer, debounce counter, edge pulse), instantiated 5 times.

Test Plan:
1. Reset with DEBOUNCE_CYCLES=4 -> CURSOR_ADDR=52, SELECT_EN=0, MOVE_REQ=0; outputs held while RESET low.
2. Cursor at 55 (row 6, col 7), press RIGHT -> 48 at exactly edge k+7. Cursor at 4, press UP -> 60. 3-cycle glitch on LEFT -> no change.
3. Square 52 = 4'b0001, TURN=0, CENTER -> SELECT_EN=1, SELECT_ADDR=52. UP twice -> cursor 36. CENTER -> MOVE_REQ=1, FROM=52, TO=36, held for 5 cycles with ACK low. ACK=1, OK=1 -> next edge MOVE_REQ=0, SELECT_EN=0, FSM=IDLE.
4. TURN=0: CENTER on square holding 4'b1001 -> no selection. CENTER on empty square -> no selection. Select 52, CENTER again at 52 -> SELECT_EN=0.
5. Select 52, move to 51 (4'b0100, own rook), CENTER -> SELECT_ADDR=51, no MOVE_REQ. Then request to 43, ACK=1, OK=0 -> MOVE_REQ=0, SELECT_EN=1, SELECT_ADDR=51. Pulses during REQUEST leave cursor unchanged.
6. RESET low while MOVE_REQ=1 -> MOVE_REQ=0 and SELECT_EN=0 before the next CLK edge. UP and RIGHT pulses in the same cycle -> only UP applied.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess definitions for the player-input stage.
//   - Piece codes (3 bits) and colour encodings of a board nibble.
//   - Square address layout: 6 bits, {row[2:0], col[2:0]}.
//   - Cursor/selection FSM encoding.
//   - own_piece(): does square sq hold a piece of the side to move?
package chess_pkg;

    localparam int unsigned SQ_W  = 6;
    localparam int unsigned ROW_W = 3;
    localparam int unsigned COL_W = 3;

    typedef logic [SQ_W-1:0] sq_addr_t;

    typedef enum logic [2:0] {
        PIECE_NONE   = 3'd0,
        PIECE_PAWN   = 3'd1,
        PIECE_KNIGHT = 3'd2,
        PIECE_BISHOP = 3'd3,
        PIECE_ROOK   = 3'd4,
        PIECE_QUEEN  = 3'd5,
        PIECE_KING   = 3'd6
    } piece_e;

    localparam logic COLOR_WHITE = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECTED = 2'd1,
        REQUEST  = 2'd2
    } fsm_e;

    function automatic logic [ROW_W-1:0] sq_row(input sq_addr_t sq);
        return sq[SQ_W-1:COL_W];
    endfunction

    function automatic logic [COL_W-1:0] sq_col(input sq_addr_t sq);
        return sq[COL_W-1:0];
    endfunction

    // Square n occupies BOARD[4n+3:4n]: [2:0] piece code, [3] colour.
    function automatic logic own_piece(input logic [255:0] board, input sq_addr_t sq,
                                       input logic turn);
        logic [3:0] nib;
        nib = board[{sq, 2'b00} +: 4];
        return (nib[2:0] != PIECE_NONE) && (nib[3] == turn);
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw push-button conditioner.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   raw    : raw asynchronous button level, active-high
//   pulse  : registered one-cycle pulse on each accepted press
// A 2-flop synchronizer feeds a debounce counter; the debounced level only
// follows the synchronized level after DEBOUNCE_CYCLES consecutive
// disagreeing cycles. Only rising edges of the debounced level pulse.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic             stable_q;
    logic             stable_dly_q;
    logic             pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                // Held different long enough: accept the new level.
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            stable_dly_q <= stable_q;
            pulse_q      <= stable_q & ~stable_dly_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/board_cursor_ctrl.sv
// Player-input stage in front of the VGA board renderer.
//   CLK, RESET           : clock, asynchronous active-low reset
//   BTN_*                : raw active-high push-buttons
//   BOARD, TURN          : board contents and side to move (sampled on CENTER)
//   MOVE_ACK, MOVE_OK    : handshake response from game logic
//   CURSOR_ADDR          : {row,col} of cursor
//   SELECT_ADDR/EN       : selected square for the renderer
//   MOVE_REQ/FROM/TO     : move request to game logic
// Buttons are conditioned into single pulses; one pulse per cycle is acted
// on with priority CENTER > UP > DOWN > LEFT > RIGHT.
module board_cursor_ctrl
    import chess_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter logic [5:0]  START_ADDR      = 6'd52
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         BTN_UP,
    input  logic         BTN_DOWN,
    input  logic         BTN_LEFT,
    input  logic         BTN_RIGHT,
    input  logic         BTN_CENTER,
    input  logic [255:0] BOARD,
    input  logic         TURN,
    input  logic         MOVE_ACK,
    input  logic         MOVE_OK,
    output logic [5:0]   CURSOR_ADDR,
    output logic [5:0]   SELECT_ADDR,
    output logic         SELECT_EN,
    output logic         MOVE_REQ,
    output logic [5:0]   MOVE_FROM,
    output logic [5:0]   MOVE_TO
);

    logic pulse_up;
    logic pulse_down;
    logic pulse_left;
    logic pulse_right;
    logic pulse_center;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
        .clk   (CLK),
        .rst_n (RESET),
        .raw   (BTN_UP),
        .pulse (pulse_up)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down (
        .clk   (CLK),
        .rst_n (RESET),
        .raw   (BTN_DOWN),
        .pulse (pulse_down)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_left (
        .clk   (CLK),
        .rst_n (RESET),
        .raw   (BTN_LEFT),
        .pulse (pulse_left)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_right (
        .clk   (CLK),
        .rst_n (RESET),
        .raw   (BTN_RIGHT),
        .pulse (pulse_right)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_center (
        .clk   (CLK),
        .rst_n (RESET),
        .raw   (BTN_CENTER),
        .pulse (pulse_center)
    );

    fsm_e     state_q;
    sq_addr_t cursor_q;
    sq_addr_t sel_addr_q;
    logic     sel_en_q;
    logic     req_q;
    sq_addr_t from_q;
    sq_addr_t to_q;

    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;
    sq_addr_t         cursor_moved;
    logic             own_here;

    // Next cursor from direction pulses; row/col wrap modulo 8 by width.
    always_comb begin
        cur_row      = sq_row(cursor_q);
        cur_col      = sq_col(cursor_q);
        cursor_moved = cursor_q;
        if (pulse_up) begin
            cursor_moved = {cur_row - 3'd1, cur_col};
        end else if (pulse_down) begin
            cursor_moved = {cur_row + 3'd1, cur_col};
        end else if (pulse_left) begin
            cursor_moved = {cur_row, cur_col - 3'd1};
        end else if (pulse_right) begin
            cursor_moved = {cur_row, cur_col + 3'd1};
        end
    end

    assign own_here = own_piece(BOARD, cursor_q, TURN);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            cursor_q   <= START_ADDR;
            sel_addr_q <= '0;
            sel_en_q   <= 1'b0;
            req_q      <= 1'b0;
            from_q     <= '0;
            to_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pulse_center) begin
                        if (own_here) begin
                            sel_addr_q <= cursor_q;
                            sel_en_q   <= 1'b1;
                            state_q    <= SELECTED;
                        end
                    end else begin
                        cursor_q <= cursor_moved;
                    end
                end
                SELECTED: begin
                    if (pulse_center) begin
                        if (cursor_q == sel_addr_q) begin
                            sel_en_q <= 1'b0;
                            state_q  <= IDLE;
                        end else if (own_here) begin
                            sel_addr_q <= cursor_q;
                        end else begin
                            from_q  <= sel_addr_q;
                            to_q    <= cursor_q;
                            req_q   <= 1'b1;
                            state_q <= REQUEST;
                        end
                    end else begin
                        cursor_q <= cursor_moved;
                    end
                end
                REQUEST: begin
                    // Cursor frozen and all pulses dropped until the ack.
                    if (MOVE_ACK) begin
                        req_q <= 1'b0;
                        if (MOVE_OK) begin
                            sel_en_q <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            state_q <= SELECTED;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign CURSOR_ADDR = cursor_q;
    assign SELECT_ADDR = sel_addr_q;
    assign SELECT_EN   = sel_en_q;
    assign MOVE_REQ    = req_q;
    assign MOVE_FROM   = from_q;
    assign MOVE_TO     = to_q;

endmodule

// File: tb/tb_board_cursor_ctrl.sv
module tb_board_cursor_ctrl;

    localparam logic [4:0] B_UP     = 5'b00001;
    localparam logic [4:0] B_DOWN   = 5'b00010;
    localparam logic [4:0] B_LEFT   = 5'b00100;
    localparam logic [4:0] B_RIGHT  = 5'b01000;
    localparam logic [4:0] B_CENTER = 5'b10000;

    logic         clk;
    logic         rst_n;
    logic [4:0]   btn;
    logic [255:0] board;
    logic         turn;
    logic         ack;
    logic         ok;
    logic [5:0]   cursor_addr;
    logic [5:0]   select_addr;
    logic         select_en;
    logic         move_req;
    logic [5:0]   move_from;
    logic [5:0]   move_to;

    board_cursor_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .START_ADDR      (6'd52)
    ) dut (
        .CLK         (clk),
        .RESET       (rst_n),
        .BTN_UP      (btn[0]),
        .BTN_DOWN    (btn[1]),
        .BTN_LEFT    (btn[2]),
        .BTN_RIGHT   (btn[3]),
        .BTN_CENTER  (btn[4]),
        .BOARD       (board),
        .TURN        (turn),
        .MOVE_ACK    (ack),
        .MOVE_OK     (ok),
        .CURSOR_ADDR (cursor_addr),
        .SELECT_ADDR (select_addr),
        .SELECT_EN   (select_en),
        .MOVE_REQ    (move_req),
        .MOVE_FROM   (move_from),
        .MOVE_TO     (move_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [5:0] cur;
        logic [5:0] sel;
        logic       en;
        logic       req;
        logic [5:0] from;
        logic [5:0] to;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic expect_st(input string tag, input logic [5:0] cur, input logic [5:0] sel,
                             input logic en, input logic req, input logic [5:0] from,
                             input logic [5:0] to);
        exp_t e;
        e.tag  = tag;
        e.cur  = cur;
        e.sel  = sel;
        e.en   = en;
        e.req  = req;
        e.from = from;
        e.to   = to;
        sb_q.push_back(e);
    endtask

    task automatic sb_compare();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check_val({e.tag, ".cur"},  32'(cursor_addr), 32'(e.cur));
        check_val({e.tag, ".sel"},  32'(select_addr), 32'(e.sel));
        check_val({e.tag, ".en"},   32'(select_en),   32'(e.en));
        check_val({e.tag, ".req"},  32'(move_req),    32'(e.req));
        check_val({e.tag, ".from"}, 32'(move_from),   32'(e.from));
        check_val({e.tag, ".to"},   32'(move_to),     32'(e.to));
    endtask

    // Press buttons in mask; raw level first sampled at edge k, result due at k+7.
    // With timed set, the unchanged state at k+6 is popped first.
    task automatic press(input logic [4:0] mask, input bit timed);
        @(negedge clk);
        btn = btn | mask;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        if (timed) sb_compare();
        @(posedge clk);
        #1;
        sb_compare();
        @(negedge clk);
        btn = btn & ~mask;
        repeat (10) @(posedge clk);
    endtask

    task automatic handshake(input logic move_ok);
        @(negedge clk);
        ack = 1'b1;
        ok  = move_ok;
        @(posedge clk);
        #1;
        sb_compare();
        @(negedge clk);
        ack = 1'b0;
        ok  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = '0;
        ack   = 1'b0;
        ok    = 1'b0;
        turn  = 1'b0;
        board = '0;
        board[52*4 +: 4] = 4'b0001;  // white pawn
        board[51*4 +: 4] = 4'b0100;  // white rook
        board[53*4 +: 4] = 4'b1001;  // black pawn

        // Reset state, held across edges while reset is low.
        repeat (3) @(posedge clk);
        #1;
        expect_st("rst", 6'd52, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
        sb_compare();
        repeat (2) @(posedge clk);
        #1;
        expect_st("rst_hold", 6'd52, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
        sb_compare();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Cursor movement and wrap.
        expect_st("r53", 6'd53, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0); press(B_RIGHT, 1'b0);
        expect_st("r54", 6'd54, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0); press(B_RIGHT, 1'b0);
        expect_st("r55", 6'd55, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0); press(B_RIGHT, 1'b0);
        expect_st("rwrap_pre", 6'd55, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
        expect_st("rwrap", 6'd48, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
        press(B_RIGHT, 1'b1);
        expect_st("d56", 6'd56, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0); press(B_DOWN, 1'b0);
        expect_st("dwrap", 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0); press(B_DOWN, 1'b0);
        expect_st("r1", 6'd1, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0); press(B_RIGHT, 1'b0);
        expect_st("r2", 6'd2, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0); press(B_RIGHT, 1'b0);
        expect_st("r3", 6'd3, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0); press(B_RIGHT, 1'b0);
        expect_st("r4", 6'd4, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0); press(B_RIGHT, 1'b0);
        expect_st("uwrap_pre", 6'd4, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
        expect_st("uwrap", 6'd60, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
        press(B_UP, 1'b1);

        // 3-cycle glitch on LEFT is filtered.
        @(negedge clk);
        btn = B_LEFT;
        repeat (3) @(negedge clk);
        btn = '0;
        repeat (12) @(posedge clk);
        #1;
        expect_st("glitch", 6'd60, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
        sb_compare();

        // Reset pulse returns cursor to start.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_st("rst2", 6'd52, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
        sb_compare();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Non-selectable squares, then select/deselect.
        expect_st("to53", 6'd53, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0); press(B_RIGHT, 1'b0);
        expect_st("c_enemy", 6'd53, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0); press(B_CENTER, 1'b0);
        expect_st("to45", 6'd45, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0); press(B_UP, 1'b0);
        expect_st("c_empty", 6'd45, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0); press(B_CENTER, 1'b0);
        expect_st("back53", 6'd53, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0); press(B_DOWN, 1'b0);
        expect_st("back52", 6'd52, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0); press(B_LEFT, 1'b0);
        expect_st("sel52", 6'd52, 6'd52, 1'b1, 1'b0, 6'd0, 6'd0); press(B_CENTER, 1'b0);
        expect_st("desel", 6'd52, 6'd52, 1'b0, 1'b0, 6'd0, 6'd0); press(B_CENTER, 1'b0);

        // Accepted move.
        expect_st("sel52b", 6'd52, 6'd52, 1'b1, 1'b0, 6'd0, 6'd0); press(B_CENTER, 1'b0);
        expect_st("u44", 6'd44, 6'd52, 1'b1, 1'b0, 6'd0, 6'd0); press(B_UP, 1'b0);
        expect_st("u36", 6'd36, 6'd52, 1'b1, 1'b0, 6'd0, 6'd0); press(B_UP, 1'b0);
        expect_st("req", 6'd36, 6'd52, 1'b1, 1'b1, 6'd52, 6'd36); press(B_CENTER, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            expect_st($sformatf("req_hold%0d", i), 6'd36, 6'd52, 1'b1, 1'b1, 6'd52, 6'd36);
            sb_compare();
        end
        expect_st("ack_ok", 6'd36, 6'd52, 1'b0, 1'b0, 6'd52, 6'd36);
        handshake(1'b1);

        // Reselect, rejected move, pulses ignored during request.
        expect_st("d44", 6'd44, 6'd52, 1'b0, 1'b0, 6'd52, 6'd36); press(B_DOWN, 1'b0);
        expect_st("d52", 6'd52, 6'd52, 1'b0, 1'b0, 6'd52, 6'd36); press(B_DOWN, 1'b0);
        expect_st("sel52c", 6'd52, 6'd52, 1'b1, 1'b0, 6'd52, 6'd36); press(B_CENTER, 1'b0);
        expect_st("l51", 6'd51, 6'd52, 1'b1, 1'b0, 6'd52, 6'd36); press(B_LEFT, 1'b0);
        expect_st("resel51", 6'd51, 6'd51, 1'b1, 1'b0, 6'd52, 6'd36); press(B_CENTER, 1'b0);
        expect_st("u43", 6'd43, 6'd51, 1'b1, 1'b0, 6'd52, 6'd36); press(B_UP, 1'b0);
        expect_st("req2", 6'd43, 6'd51, 1'b1, 1'b1, 6'd51, 6'd43); press(B_CENTER, 1'b0);
        expect_st("frozen", 6'd43, 6'd51, 1'b1, 1'b1, 6'd51, 6'd43); press(B_RIGHT, 1'b0);
        expect_st("ack_rej", 6'd43, 6'd51, 1'b1, 1'b0, 6'd51, 6'd43);
        handshake(1'b0);
        expect_st("req3", 6'd43, 6'd51, 1'b1, 1'b1, 6'd51, 6'd43); press(B_CENTER, 1'b0);

        // Asynchronous reset during a request.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_st("rst_req", 6'd52, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
        sb_compare();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Simultaneous UP and RIGHT: only UP applies.
        expect_st("prio", 6'd44, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
        press(B_UP | B_RIGHT, 1'b0);

        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
